// File: rtl/morse_keyer.sv
// morse_keyer: turns accepted ASCII characters into an ITU Morse on/off
// keying waveform on key, with busy/letter_done/overrun/bad_char status.
module morse_keyer #(
   parameter int unsigned UNIT_CYCLES = 1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       new_letter,
   input  logic [7:0] char_in,
   output logic       key,
   output logic       busy,
   output logic       letter_done,
   output logic       overrun,
   output logic       bad_char
);

   typedef enum logic [2:0] {IDLE, MARK, ESPACE, LGAP, WGAP} state_t;

   localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(UNIT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [7:0]       char_q, char_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [1:0]       unit_q, unit_d;
   logic [2:0]       elem_q, elem_d;
   logic             overrun_q, overrun_d;
   logic             bad_q, bad_d;

   logic [2:0]       len;
   logic [4:0]       pat;
   logic             is_dash;
   logic [1:0]       units_last;
   logic             unit_end;
   logic             state_done;

   // Letters and digits are the only supported non-space characters.
   function automatic logic is_supported(input logic [7:0] c);
      return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z") ||
             (c >= "0" && c <= "9");
   endfunction

   // Returns {length, pattern}; pattern is left-aligned so element i is
   // bit [4-i], 1 = dash, 0 = dot. Lowercase folds onto uppercase.
   function automatic logic [7:0] lookup(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
      case (u)
         "A": return {3'd2, 5'b01000};
         "B": return {3'd4, 5'b10000};
         "C": return {3'd4, 5'b10100};
         "D": return {3'd3, 5'b10000};
         "E": return {3'd1, 5'b00000};
         "F": return {3'd4, 5'b00100};
         "G": return {3'd3, 5'b11000};
         "H": return {3'd4, 5'b00000};
         "I": return {3'd2, 5'b00000};
         "J": return {3'd4, 5'b01110};
         "K": return {3'd3, 5'b10100};
         "L": return {3'd4, 5'b01000};
         "M": return {3'd2, 5'b11000};
         "N": return {3'd2, 5'b10000};
         "O": return {3'd3, 5'b11100};
         "P": return {3'd4, 5'b01100};
         "Q": return {3'd4, 5'b11010};
         "R": return {3'd3, 5'b01000};
         "S": return {3'd3, 5'b00000};
         "T": return {3'd1, 5'b10000};
         "U": return {3'd3, 5'b00100};
         "V": return {3'd4, 5'b00010};
         "W": return {3'd3, 5'b01100};
         "X": return {3'd4, 5'b10010};
         "Y": return {3'd4, 5'b10110};
         "Z": return {3'd4, 5'b11000};
         "0": return {3'd5, 5'b11111};
         "1": return {3'd5, 5'b01111};
         "2": return {3'd5, 5'b00111};
         "3": return {3'd5, 5'b00011};
         "4": return {3'd5, 5'b00001};
         "5": return {3'd5, 5'b00000};
         "6": return {3'd5, 5'b10000};
         "7": return {3'd5, 5'b11000};
         "8": return {3'd5, 5'b11100};
         "9": return {3'd5, 5'b11110};
         default: return '0;
      endcase
   endfunction

   // Decode the latched character and work out when the current state ends.
   always_comb begin
      {len, pat} = lookup(char_q);
      is_dash    = pat[3'd4 - elem_q];
      unit_end   = (cyc_q == CYC_LAST);
      case (state_q)
         MARK:    units_last = is_dash ? 2'd2 : 2'd0;
         LGAP:    units_last = 2'd2;
         WGAP:    units_last = 2'd3;
         default: units_last = 2'd0;
      endcase
      state_done = unit_end && (unit_q == units_last);
   end

   // Next-state, counters, acceptance and pulse generation.
   always_comb begin
      state_d   = state_q;
      char_d    = char_q;
      cyc_d     = cyc_q;
      unit_d    = unit_q;
      elem_d    = elem_q;
      overrun_d = new_letter && (state_q != IDLE);
      bad_d     = 1'b0;

      if (state_q != IDLE) begin
         if (unit_end) begin
            cyc_d  = '0;
            unit_d = unit_q + 1'b1;
         end else begin
            cyc_d = cyc_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (new_letter) begin
               char_d = char_in;
               if (char_in == " ")
                  state_d = WGAP;
               else if (is_supported(char_in))
                  state_d = MARK;
               else
                  bad_d = 1'b1;
            end
         end
         MARK: begin
            if (state_done) begin
               unit_d  = '0;
               state_d = (elem_q == len - 3'd1) ? LGAP : ESPACE;
            end
         end
         ESPACE: begin
            if (state_done) begin
               unit_d  = '0;
               elem_d  = elem_q + 3'd1;
               state_d = MARK;
            end
         end
         LGAP, WGAP: begin
            if (state_done) begin
               unit_d  = '0;
               elem_d  = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         char_q    <= '0;
         cyc_q     <= '0;
         unit_q    <= '0;
         elem_q    <= '0;
         overrun_q <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         char_q    <= char_d;
         cyc_q     <= cyc_d;
         unit_q    <= unit_d;
         elem_q    <= elem_d;
         overrun_q <= overrun_d;
         bad_q     <= bad_d;
      end
   end

   assign key         = (state_q == MARK);
   assign busy        = (state_q != IDLE);
   assign letter_done = ((state_q == LGAP) || (state_q == WGAP)) && state_done;
   assign overrun     = overrun_q;
   assign bad_char    = bad_q;

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer: one instance at UNIT_CYCLES=1, one at 4.
// Cycle n of a character is the cycle after edge n-1; edge 0 accepts it.
module tb_morse_keyer;

   logic       clk = 1'b0;
   logic       rst;
   logic       nl1, nl4;
   logic [7:0] ch1, ch4;
   logic       k1, b1, ld1, ov1, bc1;
   logic       k4, b4, ld4, ov4, bc4;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   morse_keyer #(.UNIT_CYCLES(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .new_letter(nl1), .char_in(ch1),
      .key(k1), .busy(b1), .letter_done(ld1), .overrun(ov1), .bad_char(bc1)
   );

   morse_keyer #(.UNIT_CYCLES(4), .CNT_W(8)) dut4 (
      .clk(clk), .rst(rst), .new_letter(nl4), .char_in(ch4),
      .key(k4), .busy(b4), .letter_done(ld4), .overrun(ov4), .bad_char(bc4)
   );

   task automatic check(input string tag, input int unsigned cyc,
                        input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   // Checks cycles first..last; entered at the negedge of cycle first,
   // returns at the negedge of cycle last. Vector bit c-1 is cycle c.
   task automatic run_chk(input string tag, input bit sel4,
                          input int unsigned first, input int unsigned last,
                          input logic [31:0] ek, input logic [31:0] eb,
                          input logic [31:0] el, input logic [31:0] eo,
                          input logic [31:0] ec);
      for (int unsigned c = first; c <= last; c++) begin
         if (c != first) @(negedge clk);
         check({tag, ".key"},         c, sel4 ? k4  : k1,  ek[c-1]);
         check({tag, ".busy"},        c, sel4 ? b4  : b1,  eb[c-1]);
         check({tag, ".letter_done"}, c, sel4 ? ld4 : ld1, el[c-1]);
         check({tag, ".overrun"},     c, sel4 ? ov4 : ov1, eo[c-1]);
         check({tag, ".bad_char"},    c, sel4 ? bc4 : bc1, ec[c-1]);
      end
   endtask

   // Presents a one-cycle strobe, returning at the negedge after its edge.
   task automatic strobe(input bit sel4, input logic [7:0] c);
      if (sel4) begin nl4 = 1'b1; ch4 = c; end
      else      begin nl1 = 1'b1; ch1 = c; end
      @(negedge clk);
      nl1 = 1'b0;
      nl4 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; nl1 = 1'b0; nl4 = 1'b0; ch1 = '0; ch4 = '0;
      repeat (2) @(negedge clk);
      run_chk("reset1", 1'b0, 1, 1, '0, '0, '0, '0, '0);
      run_chk("reset4", 1'b1, 1, 1, '0, '0, '0, '0, '0);
      rst = 1'b0;
      @(negedge clk);

      // E, then a strobe in its final LGAP cycle is dropped as overrun.
      strobe(1'b0, "E");
      run_chk("E", 1'b0, 1, 4, 32'h1, 32'hF, 32'h8, 32'h10, '0);
      strobe(1'b0, "T");
      run_chk("E", 1'b0, 5, 7, 32'h1, 32'hF, 32'h8, 32'h10, '0);

      // S then O 18 cycles later.
      strobe(1'b0, "S");
      run_chk("S", 1'b0, 1, 18, 32'h15, 32'hFF, 32'h80, '0, '0);
      strobe(1'b0, "O");
      run_chk("O", 1'b0, 1, 16, 32'h777, 32'h3FFF, 32'h2000, '0, '0);

      // Digit 0, with a strobe during cycle 18 that must be dropped.
      strobe(1'b0, "0");
      run_chk("zero", 1'b0, 1, 18, 32'h77777, 32'h3FFFFF, 32'h200000, 32'h40000, '0);
      strobe(1'b0, "E");
      run_chk("zero", 1'b0, 19, 24, 32'h77777, 32'h3FFFFF, 32'h200000, 32'h40000, '0);

      // A, then space strobed in the first idle cycle gives a 4-unit WGAP.
      strobe(1'b0, "A");
      run_chk("A_sp", 1'b0, 1, 9, 32'h1D, 32'h1EFF, 32'h1080, '0, '0);
      strobe(1'b0, " ");
      run_chk("A_sp", 1'b0, 10, 14, 32'h1D, 32'h1EFF, 32'h1080, '0, '0);

      // Unsupported character.
      strobe(1'b0, "#");
      run_chk("hash", 1'b0, 1, 3, '0, '0, '0, '0, 32'h1);

      // Lowercase and uppercase D share a waveform.
      strobe(1'b0, "d");
      run_chk("d_lc", 1'b0, 1, 11, 32'h57, 32'h3FF, 32'h200, '0, '0);
      strobe(1'b0, "D");
      run_chk("D_uc", 1'b0, 1, 11, 32'h57, 32'h3FF, 32'h200, '0, '0);

      // T at four cycles per unit.
      strobe(1'b1, "T");
      run_chk("T4", 1'b1, 1, 26, 32'hFFF, 32'hFFFFFF, 32'h800000, '0, '0);

      // Reset sampled at the end of cycle 6 of O aborts it outright.
      strobe(1'b0, "O");
      run_chk("O_rst", 1'b0, 1, 6, 32'h37, 32'h3F, '0, '0, '0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_chk("O_rst", 1'b0, 7, 8, '0, '0, '0, '0, '0);
      strobe(1'b0, "E");
      run_chk("E_post", 1'b0, 1, 5, 32'h1, 32'hF, 32'h8, '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected end of directed sequence");
      $fatal(1, "watchdog expired");
   end

endmodule
